// File: rtl/otg_hpi_responder.sv
// ---------------------------------------------------------------------------
// otg_hpi_responder
//   HPI target modelling the CY7C67200 host port, answering the NIOS otg_hpi
//   PIO master cycles on the same clock. Provides a word RAM behind an
//   auto-incrementing byte pointer, a bidirectional mailbox and a status
//   register, so the HPI driver can be brought up in loopback without the
//   EZ-OTG chip.
//
// Parameters
//   RAM_WORDS  16-bit words of target RAM (power of 2); byte space 2*RAM_WORDS
//
// Ports
//   clk_clk                 in   system clock (PIO domain)
//   reset_reset             in   synchronous active-high reset
//   otg_hpi_address[1:0]    in   0=DATA 1=MAILBOX 2=ADDRESS 3=STATUS
//   otg_hpi_cs_n            in   chip select, active low
//   otg_hpi_r_n             in   read strobe, active low
//   otg_hpi_w_n             in   write strobe, active low
//   otg_hpi_data_from_host  in   host write data
//   otg_hpi_data_to_host    out  host read data, held until the next read
//   mbx_in_data             out  last mailbox word written by the host
//   mbx_in_valid            out  STATUS.MBX_IN
//   mbx_in_ack              in   pulse: clear MBX_IN and OVR
//   mbx_out_data            in   local mailbox word for the host
//   mbx_out_wr              in   pulse: latch mbx_out_data, set MBX_OUT
//   otg_hpi_int             out  host interrupt
//
// Configuration
//   OTG_HPI_IRQ_EN  defined: otg_hpi_int follows the registered MBX_OUT flag.
//                   undefined: otg_hpi_int is tied low.
// ---------------------------------------------------------------------------
module otg_hpi_responder #(
  parameter int unsigned RAM_WORDS = 4096
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [1:0]  otg_hpi_address,
  input  logic        otg_hpi_cs_n,
  input  logic        otg_hpi_r_n,
  input  logic        otg_hpi_w_n,
  input  logic [15:0] otg_hpi_data_from_host,
  output logic [15:0] otg_hpi_data_to_host,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr,
  output logic        otg_hpi_int
);

  localparam int unsigned AW       = $clog2(RAM_WORDS);
  localparam logic [15:0] PTR_MASK = 16'(2 * RAM_WORDS - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MAILBOX = 2'd1;
  localparam logic [1:0] ADDR_ADDRESS = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_WR_HOLD   = 2'd2;
  localparam logic [1:0] ST_RD_HOLD   = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [15:0]   r_ptr;
  logic [15:0]   r_ram [RAM_WORDS];
  logic [15:0]   r_ram_q;
  logic [15:0]   r_rd_reg;
  logic          r_rd_from_ram;
  logic [1:0]    r_rd_addr;
  logic [15:0]   r_mbx_in_data;
  logic          r_mbx_in;
  logic          r_ovr;
  logic [15:0]   r_mbx_out_data;
  logic          r_mbx_out;

  logic          w_rd;
  logic          w_wr;
  logic          w_illegal;
  logic          w_commit_wr;
  logic          w_rd_start;
  logic          w_rd_end;
  logic          w_ram_we;
  logic          w_ram_re;
  logic [AW-1:0] w_ram_idx;
  logic [15:0]   w_ptr_inc;
  logic [15:0]   w_status;
  logic          w_host_mbx_wr;
  logic          w_host_mbx_rd_end;

  // Strobe decode; PIOs are registered in this clock domain so no sync.
  assign w_rd      = ~otg_hpi_cs_n & ~otg_hpi_r_n &  otg_hpi_w_n;
  assign w_wr      = ~otg_hpi_cs_n & ~otg_hpi_w_n &  otg_hpi_r_n;
  assign w_illegal = ~otg_hpi_cs_n & ~otg_hpi_r_n & ~otg_hpi_w_n;

  assign w_commit_wr = (r_state == ST_IDLE) & w_wr;
  assign w_rd_start  = (r_state == ST_IDLE) & w_rd;
  // Read side effects are applied when the strobe ends, using the address
  // captured at strobe start; an illegal overlap aborts without side effect.
  assign w_rd_end    = (r_state == ST_RD_HOLD) & ~w_rd & ~w_illegal;

  assign w_ram_idx = r_ptr[AW:1];
  assign w_ram_we  = w_commit_wr & (otg_hpi_address == ADDR_DATA);
  assign w_ram_re  = w_rd_start  & (otg_hpi_address == ADDR_DATA);
  assign w_ptr_inc = (r_ptr + 16'd2) & PTR_MASK;
  assign w_status  = {13'b0, r_ovr, r_mbx_in, r_mbx_out};

  assign w_host_mbx_wr     = w_commit_wr & (otg_hpi_address == ADDR_MAILBOX);
  assign w_host_mbx_rd_end = w_rd_end & (r_rd_addr == ADDR_MAILBOX);

  // FSM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_IDLE: if (otg_hpi_cs_n) w_state_next = ST_IDLE;
      ST_IDLE: begin
        if (w_wr)      w_state_next = ST_WR_HOLD;
        else if (w_rd) w_state_next = ST_RD_HOLD;
      end
      ST_WR_HOLD: begin
        if (w_illegal)  w_state_next = ST_WAIT_IDLE;
        else if (!w_wr) w_state_next = ST_IDLE;
      end
      ST_RD_HOLD: begin
        if (w_illegal)  w_state_next = ST_WAIT_IDLE;
        else if (!w_rd) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_state <= ST_WAIT_IDLE;
    else             r_state <= w_state_next;
  end

  // Byte pointer: bit 0 always zero, increments wrap within the RAM space.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_ptr <= '0;
    end else if (w_commit_wr) begin
      if (otg_hpi_address == ADDR_DATA)
        r_ptr <= w_ptr_inc;
      else if (otg_hpi_address == ADDR_ADDRESS)
        r_ptr <= otg_hpi_data_from_host & 16'hFFFE;
    end else if (w_rd_end && (r_rd_addr == ADDR_DATA)) begin
      r_ptr <= w_ptr_inc;
    end
  end

  // Single-port block RAM; the enabled output register doubles as the
  // DATA read holding register, so it is not reset.
  always_ff @(posedge clk_clk) begin
    if (w_ram_we) r_ram[w_ram_idx] <= otg_hpi_data_from_host;
    if (w_ram_re) r_ram_q <= r_ram[w_ram_idx];
  end

  // Non-RAM read capture; the output mux selects RAM or register data.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rd_reg      <= '0;
      r_rd_from_ram <= 1'b0;
      r_rd_addr     <= ADDR_DATA;
    end else if (w_rd_start) begin
      r_rd_addr     <= otg_hpi_address;
      r_rd_from_ram <= (otg_hpi_address == ADDR_DATA);
      case (otg_hpi_address)
        ADDR_MAILBOX: r_rd_reg <= r_mbx_out_data;
        ADDR_ADDRESS: r_rd_reg <= r_ptr;
        ADDR_STATUS:  r_rd_reg <= w_status;
        default:      r_rd_reg <= '0;
      endcase
    end
  end

  assign otg_hpi_data_to_host = r_rd_from_ram ? r_ram_q : r_rd_reg;

  // Mailboxes. A host write in the same cycle as mbx_in_ack keeps MBX_IN set
  // but clears OVR; mbx_out_wr wins over the host read clearing MBX_OUT.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_mbx_in_data  <= '0;
      r_mbx_in       <= 1'b0;
      r_ovr          <= 1'b0;
      r_mbx_out_data <= '0;
      r_mbx_out      <= 1'b0;
    end else begin
      if (w_host_mbx_wr) r_mbx_in_data <= otg_hpi_data_from_host;

      if (w_host_mbx_wr)   r_mbx_in <= 1'b1;
      else if (mbx_in_ack) r_mbx_in <= 1'b0;

      if (mbx_in_ack)                     r_ovr <= 1'b0;
      else if (w_host_mbx_wr && r_mbx_in) r_ovr <= 1'b1;

      if (mbx_out_wr) begin
        r_mbx_out_data <= mbx_out_data;
        r_mbx_out      <= 1'b1;
      end else if (w_host_mbx_rd_end) begin
        r_mbx_out      <= 1'b0;
      end
    end
  end

  assign mbx_in_data  = r_mbx_in_data;
  assign mbx_in_valid = r_mbx_in;

`ifdef OTG_HPI_IRQ_EN
  assign otg_hpi_int = r_mbx_out;
`else
  assign otg_hpi_int = 1'b0;
`endif

endmodule

// File: tb/tb_otg_hpi_responder.sv
// ---------------------------------------------------------------------------
// tb_otg_hpi_responder
//   Directed bench for otg_hpi_responder: host PIO cycles driven on the
//   falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_otg_hpi_responder;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

`ifdef OTG_HPI_IRQ_EN
  localparam logic EXP_IRQ = 1'b1;
`else
  localparam logic EXP_IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        cs_n, r_n, w_n;
  logic [15:0] din;
  logic [15:0] dout;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack;
  logic [15:0] mbx_out_data;
  logic        mbx_out_wr;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] rd;

  always #5 clk = ~clk;

  otg_hpi_responder #(.RAM_WORDS(4096)) dut (
    .clk_clk                (clk),
    .reset_reset            (reset),
    .otg_hpi_address        (addr),
    .otg_hpi_cs_n           (cs_n),
    .otg_hpi_r_n            (r_n),
    .otg_hpi_w_n            (w_n),
    .otg_hpi_data_from_host (din),
    .otg_hpi_data_to_host   (dout),
    .mbx_in_data            (mbx_in_data),
    .mbx_in_valid           (mbx_in_valid),
    .mbx_in_ack             (mbx_in_ack),
    .mbx_out_data           (mbx_out_data),
    .mbx_out_wr             (mbx_out_wr),
    .otg_hpi_int            (irq)
  );

  task automatic check_val(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; din = d; cs_n = 1'b0; w_n = 1'b0;
    @(negedge clk);
    cs_n = 1'b1; w_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic host_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; cs_n = 1'b0; r_n = 1'b0;
    @(negedge clk);
    d = dout;
    cs_n = 1'b1; r_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    mbx_in_ack = 1'b1;
    @(negedge clk);
    mbx_in_ack = 1'b0;
  endtask

  task automatic out_pulse(input logic [15:0] d);
    @(negedge clk);
    mbx_out_data = d; mbx_out_wr = 1'b1;
    @(negedge clk);
    mbx_out_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr = A_DATA; cs_n = 1'b1; r_n = 1'b1; w_n = 1'b1;
    din = '0; mbx_in_ack = 1'b0; mbx_out_data = '0; mbx_out_wr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_val("rst_dout", dout, 16'h0000);
    check_val("rst_mbx_in_data", mbx_in_data, 16'h0000);
    check_val("rst_mbx_in_valid", {15'b0, mbx_in_valid}, 16'h0000);
    check_val("rst_int", {15'b0, irq}, 16'h0000);
    host_read(A_STAT, rd); check_val("rst_status", rd, 16'h0000);
    host_read(A_ADDR, rd); check_val("rst_ptr", rd, 16'h0000);

    // 1: RAM write/read with auto-increment
    host_write(A_ADDR, 16'h0100);
    host_write(A_DATA, 16'hBEEF);
    host_write(A_DATA, 16'h1234);
    host_write(A_ADDR, 16'h0100);
    host_read(A_DATA, rd); check_val("t1_rd0", rd, 16'hBEEF);
    host_read(A_DATA, rd); check_val("t1_rd1", rd, 16'h1234);
    host_read(A_ADDR, rd); check_val("t1_ptr", rd, 16'h0104);

    // 2: pointer wrap at top of RAM, odd ADDRESS bit forced to 0
    host_write(A_ADDR, 16'h1FFE);
    host_write(A_DATA, 16'hAAAA);
    host_write(A_DATA, 16'h5555);
    host_read(A_ADDR, rd); check_val("t2_ptr_wrap", rd, 16'h0002);
    host_write(A_ADDR, 16'h0001);
    host_read(A_ADDR, rd); check_val("t2_ptr_bit0", rd, 16'h0000);
    host_read(A_DATA, rd); check_val("t2_ram0", rd, 16'h5555);
    host_write(A_ADDR, 16'h1FFE);
    host_read(A_DATA, rd); check_val("t2_ramtop", rd, 16'hAAAA);

    // 3: host -> local mailbox, overrun, ack
    host_write(A_MBX, 16'h00C3);
    check_val("t3_valid", {15'b0, mbx_in_valid}, 16'h0001);
    check_val("t3_data0", mbx_in_data, 16'h00C3);
    host_read(A_STAT, rd); check_val("t3_stat1", rd, 16'h0002);
    host_write(A_MBX, 16'h00C4);
    host_read(A_STAT, rd); check_val("t3_stat_ovr", rd, 16'h0006);
    ack_pulse();
    host_read(A_STAT, rd); check_val("t3_stat_ack", rd, 16'h0000);
    check_val("t3_data1", mbx_in_data, 16'h00C4);
    check_val("t3_valid_clr", {15'b0, mbx_in_valid}, 16'h0000);
    // ack in the same cycle as a host mailbox write: write wins, OVR clear
    host_write(A_MBX, 16'h0011);
    @(negedge clk);
    addr = A_MBX; din = 16'h0022; cs_n = 1'b0; w_n = 1'b0; mbx_in_ack = 1'b1;
    @(negedge clk);
    mbx_in_ack = 1'b0; cs_n = 1'b1; w_n = 1'b1;
    @(negedge clk);
    host_read(A_STAT, rd); check_val("t3_ack_vs_wr", rd, 16'h0002);
    check_val("t3_data2", mbx_in_data, 16'h0022);
    ack_pulse();

    // 4: local -> host mailbox and interrupt
    out_pulse(16'h7777);
    check_val("t4_int_set", {15'b0, irq}, {15'b0, EXP_IRQ});
    host_read(A_STAT, rd); check_val("t4_stat", rd, 16'h0001);
    host_read(A_MBX, rd);  check_val("t4_mbx_rd", rd, 16'h7777);
    check_val("t4_int_clr", {15'b0, irq}, 16'h0000);
    host_read(A_STAT, rd); check_val("t4_stat_clr", rd, 16'h0000);
    // mbx_out_wr on the cycle the host read clears MBX_OUT: set wins
    out_pulse(16'h1357);
    @(negedge clk);
    addr = A_MBX; cs_n = 1'b0; r_n = 1'b0;
    @(negedge clk);
    check_val("t4_mbx_old", dout, 16'h1357);
    cs_n = 1'b1; r_n = 1'b1; mbx_out_data = 16'h4242; mbx_out_wr = 1'b1;
    @(negedge clk);
    mbx_out_wr = 1'b0;
    host_read(A_STAT, rd); check_val("t4_set_wins", rd, 16'h0001);
    host_read(A_MBX, rd);  check_val("t4_mbx_new", rd, 16'h4242);

    // 5: long write strobe commits once; illegal r_n&w_n does nothing
    host_write(A_ADDR, 16'h0202);
    host_write(A_DATA, 16'h1111);
    host_write(A_ADDR, 16'h0200);
    @(negedge clk);
    addr = A_DATA; din = 16'h5A5A; cs_n = 1'b0; w_n = 1'b0;
    repeat (5) @(negedge clk);
    din = 16'h0F0F;
    repeat (5) @(negedge clk);
    cs_n = 1'b1; w_n = 1'b1;
    @(negedge clk);
    host_read(A_ADDR, rd); check_val("t5_ptr_once", rd, 16'h0202);
    host_write(A_ADDR, 16'h0200);
    host_read(A_DATA, rd); check_val("t5_ram0", rd, 16'h5A5A);
    host_read(A_DATA, rd); check_val("t5_ram1", rd, 16'h1111);
    @(negedge clk);
    addr = A_DATA; din = 16'hDEAD; cs_n = 1'b0; r_n = 1'b0; w_n = 1'b0;
    repeat (3) @(negedge clk);
    addr = A_MBX;
    repeat (3) @(negedge clk);
    cs_n = 1'b1; r_n = 1'b1; w_n = 1'b1;
    @(negedge clk);
    host_read(A_ADDR, rd); check_val("t5_illegal_ptr", rd, 16'h0204);
    host_read(A_STAT, rd); check_val("t5_illegal_stat", rd, 16'h0000);

    // 6: reset during a write strobe, no commit until cs_n goes high
    host_write(A_ADDR, 16'h0040);
    @(negedge clk);
    addr = A_DATA; din = 16'h9999; cs_n = 1'b0; w_n = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_val("t6_rst_dout", dout, 16'h0000);
    reset = 1'b0; din = 16'h6666;
    repeat (3) @(negedge clk);
    cs_n = 1'b1; w_n = 1'b1;
    @(negedge clk);
    host_read(A_ADDR, rd); check_val("t6_ptr_rst", rd, 16'h0000);
    host_read(A_DATA, rd); check_val("t6_no_commit", rd, 16'h5555);
    host_write(A_DATA, 16'hABCD);
    host_read(A_ADDR, rd); check_val("t6_ptr_after", rd, 16'h0004);
    host_write(A_ADDR, 16'h0002);
    host_read(A_DATA, rd); check_val("t6_wr_after", rd, 16'hABCD);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
